// File: rtl/com_packet_ctrl.sv
// com_packet_ctrl: packet sequencer between the byte-array registers and the
// byte-wide UART cores.
//
// TX path: on tx_start the whole tx_arr is snapshotted, then the bytes go
// out one at a time (byte 0 first). Each byte is paced by the UART busy
// flag and by the tx_block flow-control input.
// RX path: incoming bytes are collected in a shadow array. When the last
// byte of a packet arrives, the shadow is copied to rx_arr in one step. A
// packet that stalls for RX_TIMEOUT idle cycles is thrown away.
//
// Ports:
//   clk, rst_n     system clock; asynchronous active-low reset
//   rx_data        byte from serial_rx, valid while new_rx_data is high
//   new_rx_data    1-cycle strobe from serial_rx
//   tx_data        byte to serial_tx; registered and held stable
//   new_tx_data    1-cycle strobe to serial_tx
//   uart_tx_busy   serial_tx is busy shifting a byte
//   tx_block       flow control; no new byte is issued while it is high
//   tx_arr         packet to send; byte i = bits [8i+7:8i]
//   tx_start       request to send tx_arr (ignored while a send is running)
//   tx_busy        high while a packet send is in progress
//   rx_arr         last complete packet; byte i = bits [8i+7:8i]
//   new_rx         1-cycle strobe; rx_arr was just updated
//   rx_busy        high while a packet is partially received

module com_packet_ctrl #(
    parameter int DATA_SIZE  = 16,
    parameter int ADDR_SIZE  = 4,
    parameter int RX_TIMEOUT = 50000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_data,
    input  logic                   new_rx_data,
    output logic [7:0]             tx_data,
    output logic                   new_tx_data,
    input  logic                   uart_tx_busy,
    input  logic                   tx_block,
    input  logic [DATA_SIZE*8-1:0] tx_arr,
    input  logic                   tx_start,
    output logic                   tx_busy,
    output logic [DATA_SIZE*8-1:0] rx_arr,
    output logic                   new_rx,
    output logic                   rx_busy
);

    localparam logic [ADDR_SIZE-1:0] LP_LAST = ADDR_SIZE'(DATA_SIZE - 1);
    localparam logic [ADDR_SIZE-1:0] LP_ONE  = ADDR_SIZE'(1);
    localparam logic [23:0]          LP_TO   = 24'(RX_TIMEOUT);

    // ------------------------------------------------------------------
    // TX side
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_WAIT
    } tx_state_t;

    tx_state_t                     r_tx_state;
    tx_state_t                     w_tx_next;
    logic [DATA_SIZE-1:0][7:0]     r_tx_snap;
    logic [ADDR_SIZE-1:0]          r_tx_idx;
    logic [7:0]                    r_tx_data;
    logic                          r_tx_new;
    logic                          r_tx_busy;
    logic                          r_tx_hold;
    logic                          w_tx_load;
    logic                          w_tx_fire;
    logic                          w_tx_adv;
    logic                          w_tx_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= TX_IDLE;
        end else begin
            r_tx_state <= w_tx_next;
        end
    end

    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_load = 1'b0;
        w_tx_fire = 1'b0;
        w_tx_adv  = 1'b0;
        w_tx_done = 1'b0;
        unique case (r_tx_state)
            TX_IDLE: begin
                if (tx_start) begin
                    w_tx_load = 1'b1;
                    w_tx_next = TX_SEND;
                end
            end
            TX_SEND: begin
                if (!uart_tx_busy && !tx_block) begin
                    w_tx_fire = 1'b1;
                    w_tx_next = TX_WAIT;
                end
            end
            TX_WAIT: begin
                // The UART raises busy one cycle after our strobe, so the
                // first WAIT cycle must not trust a low busy flag.
                if (!r_tx_hold && !uart_tx_busy) begin
                    if (r_tx_idx == LP_LAST) begin
                        w_tx_done = 1'b1;
                        w_tx_next = TX_IDLE;
                    end else begin
                        w_tx_adv  = 1'b1;
                        w_tx_next = TX_SEND;
                    end
                end
            end
            default: begin
                w_tx_next = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_snap <= '0;
            r_tx_idx  <= '0;
            r_tx_data <= '0;
            r_tx_new  <= 1'b0;
            r_tx_busy <= 1'b0;
            r_tx_hold <= 1'b0;
        end else begin
            r_tx_new  <= w_tx_fire;
            r_tx_hold <= w_tx_fire;
            if (w_tx_load) begin
                r_tx_snap <= tx_arr;
                r_tx_idx  <= '0;
                r_tx_busy <= 1'b1;
            end
            if (w_tx_fire) begin
                r_tx_data <= r_tx_snap[r_tx_idx];
            end
            if (w_tx_adv) begin
                r_tx_idx <= r_tx_idx + LP_ONE;
            end
            if (w_tx_done) begin
                r_tx_busy <= 1'b0;
            end
        end
    end

    assign tx_data     = r_tx_data;
    assign new_tx_data = r_tx_new;
    assign tx_busy     = r_tx_busy;

    // ------------------------------------------------------------------
    // RX side
    // ------------------------------------------------------------------
    typedef enum logic {
        RX_IDLE,
        RX_RECV
    } rx_state_t;

    rx_state_t                     r_rx_state;
    rx_state_t                     w_rx_next;
    logic [DATA_SIZE-1:0][7:0]     r_rx_shadow;
    logic [DATA_SIZE-1:0][7:0]     w_rx_full;
    logic [DATA_SIZE-1:0][7:0]     r_rx_arr;
    logic [ADDR_SIZE-1:0]          r_rx_idx;
    logic [23:0]                   r_rx_cnt;
    logic                          r_rx_new;
    logic                          r_rx_busy;
    logic                          w_rx_last;
    logic                          w_rx_tmo;
    logic                          w_rx_store;
    logic                          w_rx_commit;
    logic                          w_rx_drop;

    assign w_rx_last = (r_rx_idx == LP_LAST);

    // Counter value after this idle cycle matches the limit; a limit of
    // zero never matches, and a saturated counter wraps +1 to zero.
    assign w_rx_tmo = (LP_TO != 24'd0) &&
                      ((r_rx_cnt + 24'd1) == LP_TO);

    // Shadow with the incoming byte already merged, so the final byte can
    // be committed on the same edge it arrives.
    always_comb begin
        w_rx_full = r_rx_shadow;
        w_rx_full[r_rx_idx] = rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= RX_IDLE;
        end else begin
            r_rx_state <= w_rx_next;
        end
    end

    always_comb begin
        w_rx_next   = r_rx_state;
        w_rx_store  = 1'b0;
        w_rx_commit = 1'b0;
        w_rx_drop   = 1'b0;
        unique case (r_rx_state)
            RX_IDLE: begin
                if (new_rx_data) begin
                    w_rx_store = 1'b1;
                    if (w_rx_last) begin
                        w_rx_commit = 1'b1;
                    end else begin
                        w_rx_next = RX_RECV;
                    end
                end
            end
            RX_RECV: begin
                if (new_rx_data) begin
                    w_rx_store = 1'b1;
                    if (w_rx_last) begin
                        w_rx_commit = 1'b1;
                        w_rx_next   = RX_IDLE;
                    end
                end else if (w_rx_tmo) begin
                    w_rx_drop = 1'b1;
                    w_rx_next = RX_IDLE;
                end
            end
            default: begin
                w_rx_next = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_shadow <= '0;
            r_rx_arr    <= '0;
            r_rx_idx    <= '0;
            r_rx_cnt    <= '0;
            r_rx_new    <= 1'b0;
            r_rx_busy   <= 1'b0;
        end else begin
            r_rx_new <= w_rx_commit;
            if (w_rx_store) begin
                r_rx_shadow <= w_rx_full;
            end
            if (w_rx_store || w_rx_drop) begin
                r_rx_cnt <= '0;
            end else if (r_rx_state == RX_RECV && r_rx_cnt != '1) begin
                r_rx_cnt <= r_rx_cnt + 24'd1;
            end
            if (w_rx_commit) begin
                r_rx_arr  <= w_rx_full;
                r_rx_idx  <= '0;
                r_rx_busy <= 1'b0;
            end else if (w_rx_store) begin
                r_rx_idx  <= r_rx_idx + LP_ONE;
                r_rx_busy <= 1'b1;
            end else if (w_rx_drop) begin
                r_rx_idx  <= '0;
                r_rx_busy <= 1'b0;
            end
        end
    end

    assign rx_arr  = r_rx_arr;
    assign new_rx  = r_rx_new;
    assign rx_busy = r_rx_busy;

endmodule
